// File: rtl/fpio_pkg.sv
// Shared fpio types and constants: transmit-shifter state encoding and default word width.
`timescale 1ns/1ps
package fpio_pkg;

  localparam int FPIO_DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } fpio_tx_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int fpio_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpio_bit_timer.sv
// Half-period timer: counts div_q+1 cycles per half bit and toggles phase at each half end.
`timescale 1ns/1ps
module fpio_bit_timer #(
  parameter int DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                run,
  input  logic [DIV_BITS-1:0] div_q,
  output logic                half_end,
  output logic                phase
);

  logic [DIV_BITS-1:0] half_cnt_q, half_cnt_d;
  logic                phase_q, phase_d;

  assign half_end = run && (half_cnt_q == div_q);
  assign phase    = phase_q;

  // A start coincides with the final half_end on back-to-back bytes and must win.
  always_comb begin
    half_cnt_d = half_cnt_q;
    phase_d    = phase_q;
    if (start) begin
      half_cnt_d = '0;
      phase_d    = 1'b0;
    end else if (half_end) begin
      half_cnt_d = '0;
      phase_d    = ~phase_q;
    end else if (run) begin
      half_cnt_d = half_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      phase_q    <= phase_d;
    end
  end

endmodule

// File: rtl/fpio_tx_shifter.sv
// Pops bytes from a show-ahead FIFO and shifts them out on pio_d with a generated shift
// clock and frame strobe; consecutive bytes stream without idle cycles.
`timescale 1ns/1ps
module fpio_tx_shifter
  import fpio_pkg::*;
#(
  parameter int DATA_WIDTH = FPIO_DATA_WIDTH,
  parameter int DIV_BITS   = 16,
  parameter int MSB_FIRST  = 0,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIV_BITS-1:0]   divisor,
  input  logic                  fifo_valid,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  pio_d,
  output logic                  pio_clk,
  output logic                  pio_frame,
  output logic                  busy,
  output logic                  byte_done
);

  localparam int BIT_W = fpio_cnt_width(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  fpio_tx_state_e        state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [DIV_BITS-1:0]   div_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic                  pio_d_q;
  logic                  pio_frame_q;

  logic half_end;
  logic phase;
  logic bit_end;
  logic byte_end;
  logic load;
  logic load_bit;
  logic next_bit;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_next = shift_q << 1;
      assign load_bit   = fifo_data[DATA_WIDTH-1];
      assign next_bit   = shift_next[DATA_WIDTH-1];
    end else begin : g_lsb_first
      assign shift_next = shift_q >> 1;
      assign load_bit   = fifo_data[0];
      assign next_bit   = shift_next[0];
    end
  endgenerate

  assign bit_end  = (state_q == SHIFT) && half_end && phase;
  assign byte_end = bit_end && (bit_cnt_q == LAST_BIT);

  // A pop happens from IDLE or in the last cycle of a byte, never while in reset.
  assign load = !rst && en && fifo_valid && ((state_q == IDLE) || byte_end);

  fpio_bit_timer #(
    .DIV_BITS(DIV_BITS)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (load),
    .run      (state_q == SHIFT),
    .div_q    (div_q),
    .half_end (half_end),
    .phase    (phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      pio_d_q     <= IDLE_LEVEL;
      pio_frame_q <= 1'b0;
    end else begin
      if (load) begin
        state_q     <= SHIFT;
        shift_q     <= fifo_data;
        div_q       <= divisor;
        bit_cnt_q   <= '0;
        pio_d_q     <= load_bit;
        pio_frame_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            pio_d_q     <= IDLE_LEVEL;
            pio_frame_q <= 1'b0;
          end
          SHIFT: begin
            if (byte_end) begin
              state_q     <= IDLE;
              bit_cnt_q   <= '0;
              pio_d_q     <= IDLE_LEVEL;
              pio_frame_q <= 1'b0;
            end else if (bit_end) begin
              shift_q   <= shift_next;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              pio_d_q   <= next_bit;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign fifo_rd   = load;
  assign pio_d     = pio_d_q;
  assign pio_clk   = phase;
  assign pio_frame = pio_frame_q;
  assign busy      = (state_q != IDLE);
  assign byte_done = byte_end;

endmodule

// File: tb/tb_fpio_tx_shifter.sv
// Bench for fpio_tx_shifter: FIFO model, serial receiver monitor and a byte scoreboard.
`timescale 1ns/1ps
module tb_fpio_tx_shifter;

  localparam int DW = 8;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [DB-1:0] divisor = '0;
  logic          fifo_valid;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd;
  logic          pio_d;
  logic          pio_clk;
  logic          pio_frame;
  logic          busy;
  logic          byte_done;

  always #5 clk = ~clk;

  fpio_tx_shifter #(
    .DATA_WIDTH(DW),
    .DIV_BITS  (DB),
    .MSB_FIRST (0),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .divisor   (divisor),
    .fifo_valid(fifo_valid),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .pio_d     (pio_d),
    .pio_clk   (pio_clk),
    .pio_frame (pio_frame),
    .busy      (busy),
    .byte_done (byte_done)
  );

  // Show-ahead FIFO model
  logic [7:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int bad_rd = 0;
  int cyc = 0;
  assign fifo_valid = (wr_ptr != rd_ptr);
  assign fifo_data  = fifo_mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) rd_ptr <= rd_ptr + 1;
    if (fifo_rd && !fifo_valid) bad_rd <= bad_rd + 1;
  end

  // Monitor: event logs and a receiver sampling pio_d on rising pio_clk
  int         rd_cnt = 0, done_cnt = 0, rx_wr = 0, rx_n = 0;
  int         frame_run = 0, last_frame_len = 0, last_fall = 0, rise_cyc = 0, frame_start = 0;
  int         pop_mem [64];
  int         done_mem [64];
  logic [7:0] rx_mem [64];
  logic [7:0] rx_sh = '0;
  logic       prev_clk = 1'b0, prev_frame = 1'b0, need_rise = 1'b0;
  logic [15:0] wave_d = '0, wave_c = '0;

  initial begin : mon
    int idx;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_n = 0; prev_clk = 1'b0; prev_frame = 1'b0; frame_run = 0; need_rise = 1'b0;
      end else begin
        if (fifo_rd) begin
          pop_mem[rd_cnt % 64] = cyc;
          rd_cnt++;
          need_rise = 1'b1;
          if (!busy) begin frame_start = cyc; wave_d = '0; wave_c = '0; end
        end
        if (byte_done) begin
          done_mem[done_cnt % 64] = cyc;
          done_cnt++;
        end
        if (pio_frame) begin
          frame_run++;
          idx = cyc - frame_start - 1;
          if (idx >= 0 && idx < 16) begin wave_d[idx] = pio_d; wave_c[idx] = pio_clk; end
          if (pio_clk && !prev_clk) begin
            if (need_rise) begin rise_cyc = cyc; need_rise = 1'b0; end
            rx_sh = {pio_d, rx_sh[7:1]};
            rx_n++;
            if (rx_n == 8) begin rx_mem[rx_wr % 64] = rx_sh; rx_wr++; rx_n = 0; end
          end
        end else if (prev_frame) begin
          last_frame_len = frame_run; last_fall = cyc; frame_run = 0;
        end
        prev_clk = pio_clk; prev_frame = pio_frame;
      end
    end
  end

  int checks = 0, failures = 0;
  int rx_rd = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 64] = b;
    wr_ptr++;
    exp_q.push_back(b);
  endtask

  task automatic wait_pop(input int base, input int limit);
    int n = 0;
    while (rd_cnt <= base && n < limit) begin step(); n++; end
    check("pop seen", (rd_cnt > base) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || (en && fifo_valid)) && n < limit) begin step(); n++; end
    check("idle reached", (busy || (en && fifo_valid)) ? 0 : 1, 1);
    repeat (2) step();
  endtask

  task automatic drain();
    logic [7:0] e;
    while (rx_rd < rx_wr) begin
      if (exp_q.size() == 0) begin
        check("rx unexpected byte", {56'd0, rx_mem[rx_rd % 64]}, 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        $display("rx byte=%02h exp=%02h", rx_mem[rx_rd % 64], e);
        check("rx byte", {56'd0, rx_mem[rx_rd % 64]}, {56'd0, e});
      end
      rx_rd++;
    end
  endtask

  typedef struct {
    logic [7:0]  din;
    logic [15:0] div;
    int          done_off;
    int          rise_off;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int rb, db, t, t2, bad;

    vecs[0] = '{din: 8'hA5, div: 16'd0, done_off: 16, rise_off: 2};
    vecs[1] = '{din: 8'h3C, div: 16'd1, done_off: 32, rise_off: 3};
    vecs[2] = '{din: 8'h01, div: 16'd2, done_off: 48, rise_off: 4};
    vecs[3] = '{din: 8'hFF, div: 16'd0, done_off: 16, rise_off: 2};
    vecs[4] = '{din: 8'h00, div: 16'd3, done_off: 64, rise_off: 5};
    vecs[5] = '{din: 8'h96, div: 16'd5, done_off: 96, rise_off: 7};

    rst = 1'b1;
    repeat (3) step();
    check("reset outputs", {58'd0, pio_d, pio_clk, pio_frame, busy, byte_done, fifo_rd}, 64'b100000);
    rst = 1'b0;
    step();

    // Single bytes at several bit rates
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      divisor = vecs[i].div;
      rb = rd_cnt; db = done_cnt;
      push(vecs[i].din);
      wait_pop(rb, 20);
      wait_idle(400);
      t = pop_mem[rb % 64];
      check("vec pop count", rd_cnt - rb, 1);
      check("vec done count", done_cnt - db, 1);
      check("vec done cycle", done_mem[db % 64] - t, vecs[i].done_off);
      check("vec frame fall", last_fall - t, vecs[i].done_off + 1);
      check("vec frame length", last_frame_len, vecs[i].done_off);
      check("vec first clk rise", rise_cyc - t, vecs[i].rise_off);
      if (vecs[i].div == 16'd0 && vecs[i].din == 8'hA5) begin
        check("A5 pio_d waveform", wave_d, 16'hCC33);
        check("A5 pio_clk waveform", wave_c, 16'hAAAA);
      end
      drain();
    end

    // Two queued bytes stream back to back
    en = 1'b0; divisor = 16'd2;
    push(8'h01); push(8'h80);
    rb = rd_cnt; db = done_cnt;
    en = 1'b1;
    wait_pop(rb, 20);
    wait_idle(300);
    t = pop_mem[rb % 64];
    check("b2b pop count", rd_cnt - rb, 2);
    check("b2b done count", done_cnt - db, 2);
    check("b2b first done", done_mem[db % 64] - t, 48);
    check("b2b second done", done_mem[(db + 1) % 64] - t, 96);
    check("b2b second pop", pop_mem[(rb + 1) % 64] - t, 48);
    check("b2b frame length", last_frame_len, 96);
    drain();

    // en dropped during bit 3 with a second byte waiting
    en = 1'b0; divisor = 16'd1;
    push(8'h5A); push(8'hC3);
    rb = rd_cnt; db = done_cnt;
    en = 1'b1;
    wait_pop(rb, 20);
    t = pop_mem[rb % 64];
    while (cyc < t + 13) step();
    en = 1'b0;
    wait_idle(200);
    repeat (10) step();
    check("en drop pop count", rd_cnt - rb, 1);
    check("en drop done count", done_cnt - db, 1);
    check("en drop fifo_valid", fifo_valid, 1);
    check("en drop busy", busy, 0);
    check("en drop frame fall", last_fall - t, 33);
    drain();

    // Divisor changed mid-byte only affects the next byte
    divisor = 16'd1;
    rb = rd_cnt; db = done_cnt;
    en = 1'b1;
    wait_pop(rb, 20);
    t = pop_mem[rb % 64];
    repeat (5) step();
    divisor = 16'd3;
    push(8'h7E);
    wait_idle(400);
    t2 = pop_mem[(rb + 1) % 64];
    check("div change pop count", rd_cnt - rb, 2);
    check("div change first done", done_mem[db % 64] - t, 32);
    check("div change second pop", t2 - t, 32);
    check("div change second done", done_mem[(db + 1) % 64] - t2, 64);
    drain();

    // Reset at bit 4 drops the byte in flight
    en = 1'b0; divisor = 16'd0;
    push(8'h11); push(8'h22);
    rb = rd_cnt; db = done_cnt;
    en = 1'b1;
    wait_pop(rb, 20);
    t = pop_mem[rb % 64];
    while (cyc < t + 9) step();
    rst = 1'b1;
    step();
    check("rst mid-byte outputs", {58'd0, pio_d, pio_clk, pio_frame, busy, byte_done, fifo_rd}, 64'b100000);
    rst = 1'b0;
    void'(exp_q.pop_front());
    wait_pop(rb + 1, 20);
    wait_idle(100);
    check("rst pop count", rd_cnt - rb, 2);
    check("rst done count", done_cnt - db, 1);
    check("rst fifo drained", fifo_valid, 0);
    drain();

    // Empty FIFO with en high
    en = 1'b1; rb = rd_cnt; bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if ({pio_d, pio_clk, pio_frame, busy, byte_done, fifo_rd} !== 6'b100000) bad++;
    end
    check("empty idle bad cycles", bad, 0);
    check("empty pop count", rd_cnt - rb, 0);

    check("pop while empty", bad_rd, 0);
    check("scoreboard leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
